wb_regfile: RTL

//  Write-back end of the MEM/WB pipeline register: selects memory or ALU result, commits it to a
//  32x32 register file, serves two ID-stage read ports with same-cycle write bypass, and records

---
 rtl/wb_regfile_pkg.sv | 11 +
 rtl/wb_regfile_core.sv | 47 ++++
 rtl/wb_regfile.sv | 104 ++++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file slice.
package wb_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  // Architectural zero register: never written, always reads 0.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_core.sv
// Register array: one write port, two combinational read ports, async reset.
// Entry 0 is hard-wired to zero, so no storage is built for it.
module wb_regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  assign regs[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      // Each entry captures the write data when addressed; reset clears it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (we && (waddr == ADDR_W'(gi))) begin
          q_reg <= wdata;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule : wb_regfile_core

// File: rtl/wb_regfile.sv
// Write-back stage: result mux, register commit, write-first read bypass,
// sticky overflow capture and saturating retired-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ADDR_W-1:0] rw,
  input  logic              mem_to_reg,
  input  logic              reg_wr,
  input  logic              overflow,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] busa,
  output logic [DATA_W-1:0] busb,
  input  logic              ovf_clr,
  output logic              ovf_flag,
  output logic [ADDR_W-1:0] ovf_reg,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] wdata;
  logic              wr_en;
  logic              ovf_event;
  logic [DATA_W-1:0] core_a;
  logic [DATA_W-1:0] core_b;
  logic              ovf_flag_reg;
  logic [ADDR_W-1:0] ovf_reg_reg;
  logic [CNT_W-1:0]  wr_count_reg;

  assign wdata     = mem_to_reg ? mem_data : alu_data;
  // An overflowing instruction never commits; r0 is never a real target.
  assign wr_en     = reg_wr & ~overflow & (rw != ZERO_IDX);
  assign ovf_event = reg_wr & overflow;

  wb_regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .waddr   (rw),
    .wdata   (wdata),
    .raddr_a (ra),
    .raddr_b (rb),
    .rdata_a (core_a),
    .rdata_b (core_b)
  );

  // Read ports: zero register first, then same-cycle write bypass, then the array.
  always_comb begin
    busa = core_a;
    busb = core_b;
    if (ra == ZERO_IDX) begin
      busa = '0;
    end else if (wr_en && (ra == rw)) begin
      busa = wdata;
    end
    if (rb == ZERO_IDX) begin
      busb = '0;
    end else if (wr_en && (rb == rw)) begin
      busb = wdata;
    end
  end

  // Sticky overflow: first offender is kept until cleared; a new event beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag_reg <= 1'b0;
      ovf_reg_reg  <= '0;
    end else if (ovf_event) begin
      if (!ovf_flag_reg || ovf_clr) begin
        ovf_flag_reg <= 1'b1;
        ovf_reg_reg  <= rw;
      end
    end else if (ovf_clr) begin
      ovf_flag_reg <= 1'b0;
      ovf_reg_reg  <= '0;
    end
  end

  // Retired-write counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_reg <= '0;
    end else if (wr_en && (wr_count_reg != '1)) begin
      wr_count_reg <= wr_count_reg + 1'b1;
    end
  end

  assign ovf_flag = ovf_flag_reg;
  assign ovf_reg  = ovf_reg_reg;
  assign wr_count = wr_count_reg;

endmodule : wb_regfile
